dma_slot_arbiter: RTL and testbench
===================================

DMA_SLOT_ARBITER -- requirements
Module: dma_slot_arbiter

Interface
REQ-001 SHALL have parameter HTOTAL, default 453, last hpos value of a line (227 CCK slots).
REQ-002 SHALL have parameter CPU_STARVE, default 3, consecutive denied free slots before the CPU is forced a slot.
REQ-003 clk  in  1  bus clock; all state changes on its rising edge.
REQ-004 _reset  in  1  reset; asynchronous and active-low.
REQ-005 hpos  in  9  horizontal beam counter, 0..HTOTAL, +1 per clk; slot number s = hpos[8:1].
REQ-006 dmaen  in  1  DMACON master DMA enable.
REQ-007 dsken  in  1  disk DMA enable.
REQ-008 req_dsk, req_spr, req_bpl, req_cop, req_blt, req_cpu  in  1 each  requester wants the upcoming slot.
REQ-009 req_aud  in  4  audio channel 0..3 requests.
REQ-010 blt_nasty  in  1  blitter-nasty mode: the blitter never yields to the CPU.
REQ-011 gnt_ref, gnt_dsk, gnt_spr, gnt_bpl, gnt_cop, gnt_blt, gnt_cpu  out  1 each  registered one-hot slot grants.
REQ-012 gnt_aud  out  4  registered audio grants, part of the same one-hot set.
REQ-013 dma  out  1  registered; high when any grant other than gnt_cpu is high.

Function
REQ-014 Arbitration SHALL occur only on clk edges where hpos[0]=1; grants SHALL then hold for the 2 clk of the upcoming slot n.
REQ-015 Slot n SHALL be s+1, except n=0 when hpos=HTOTAL (wrap-around).
REQ-016 At most one grant bit SHALL be high in any cycle; all grants low means an idle slot.
REQ-017 Slots 0x01, 0x03, 0x05 and 0x07 SHALL assert gnt_ref unconditionally, regardless of dmaen or any request.
REQ-018 Slots 0x09, 0x0B and 0x0D SHALL assert gnt_dsk iff req_dsk & dsken & dmaen; otherwise the slot is free.
REQ-019 Slot 0x0F+2k (k=0..3) SHALL assert gnt_aud[k] iff req_aud[k] & dmaen; otherwise the slot is free.
REQ-020 Odd slots 0x17..0x35 SHALL assert gnt_spr iff req_spr & dmaen & ~req_bpl; otherwise the slot is free.
REQ-021 Every other slot, plus each unused fixed slot above, SHALL be a free slot.
REQ-022 Free-slot priority SHALL be: bpl > cop > blt > cpu.
REQ-023 In a free slot, bitplane DMA always wins when req_bpl & dmaen.
REQ-024 gnt_cop SHALL be granted only when n is even; a copper request in an odd free slot falls through to the next priority.
REQ-025 With dmaen=0, only gnt_ref and gnt_cpu SHALL ever assert.
REQ-026 Starve counter: 2-bit, saturating at CPU_STARVE.
  - increments on each arbitration where a free slot goes to blt while req_cpu=1 and blt_nasty=0
  - clears when gnt_cpu is issued, req_cpu=0 at arbitration, or blt_nasty=1
REQ-027 When the starve counter equals CPU_STARVE and req_cpu=1, the next free slot not taken by bpl or cop SHALL go to the CPU instead of the blitter.
REQ-028 If the starve counter is saturated but bpl or cop take the free slot, the counter SHALL hold its value.
REQ-029 Simultaneous fixed-slot grant and starve condition: the fixed slot SHALL win; the starve counter is unchanged.
REQ-030 Requests SHALL be sampled only at arbitration edges; changes during a slot SHALL not alter the current grant.

Reset
REQ-031 _reset low SHALL immediately force all grants, dma and the starve counter to 0, including mid-slot.
REQ-032 After _reset rises, the first grants SHALL appear at the first arbitration edge (hpos[0]=1).

Verification
REQ-033 hpos sweeps a full line, all requests 0, dmaen=1 -> gnt_ref during slots 1,3,5,7 only; all other slots idle; dma high only in those slots.
REQ-034 hpos=HTOTAL with req_cpu=1 -> slot 0 has gnt_cpu for hpos 0..1, and the wrap is correct.
REQ-035 req_cop=1, req_cpu=1, free slots 0x40 and 0x41 -> gnt_cop in 0x40; gnt_cpu in 0x41.
REQ-036 req_blt=req_cpu=1, blt_nasty=0, 8 consecutive free slots -> pattern blt,blt,blt,cpu,blt,blt,blt,cpu.
REQ-037 Same stimulus as REQ-036 with blt_nasty=1 -> blt in all 8 slots; the starve counter stays 0.
REQ-038 Slot 0x09 granted to disk, then _reset pulsed low at hpos=0x13 -> all grants 0 asynchronously; after release, grants resume at the next odd hpos edge.

Source files
------------

// File: rtl/dma_slot_arbiter_if.sv
// Request/grant bundle between the beam-slot DMA arbiter and its requesters.
// The master side drives beam position, enables and requests; the slave side
// (the arbiter) returns one-hot slot grants and the dma flag.
interface dma_slot_arbiter_if;
    logic [8:0] hpos;
    logic       dmaen;
    logic       dsken;
    logic       req_dsk;
    logic       req_spr;
    logic       req_bpl;
    logic       req_cop;
    logic       req_blt;
    logic       req_cpu;
    logic [3:0] req_aud;
    logic       blt_nasty;
    logic       gnt_ref;
    logic       gnt_dsk;
    logic       gnt_spr;
    logic       gnt_bpl;
    logic       gnt_cop;
    logic       gnt_blt;
    logic       gnt_cpu;
    logic [3:0] gnt_aud;
    logic       dma;

    modport master (
        output hpos, dmaen, dsken, req_dsk, req_spr, req_bpl, req_cop,
               req_blt, req_cpu, req_aud, blt_nasty,
        input  gnt_ref, gnt_dsk, gnt_spr, gnt_bpl, gnt_cop, gnt_blt,
               gnt_cpu, gnt_aud, dma
    );

    modport slave (
        input  hpos, dmaen, dsken, req_dsk, req_spr, req_bpl, req_cop,
               req_blt, req_cpu, req_aud, blt_nasty,
        output gnt_ref, gnt_dsk, gnt_spr, gnt_bpl, gnt_cop, gnt_blt,
               gnt_cpu, gnt_aud, dma
    );
endinterface

// File: rtl/dma_slot_arbiter.sv
// Beam-slot DMA arbiter. On every clk edge with hpos odd it decides who owns
// the upcoming 2-clk slot: fixed refresh/disk/audio/sprite slots first, then
// free slots by bpl > cop > blt > cpu, with a small starve counter that
// forces the CPU in after CPU_STARVE consecutive blitter wins.
module dma_slot_arbiter #(
    parameter int HTOTAL     = 453,
    parameter int CPU_STARVE = 3
) (
    input logic               clk,
    input logic               _reset,
    dma_slot_arbiter_if.slave bus
);
    localparam logic [8:0] HPOS_LAST  = 9'(HTOTAL);
    localparam logic [1:0] STARVE_MAX = 2'(CPU_STARVE);

    logic       arb;
    logic [7:0] slot;
    logic [1:0] aud_idx;
    logic       free_slot;
    logic       force_cpu;

    logic       nxt_ref, nxt_dsk, nxt_spr, nxt_bpl, nxt_cop, nxt_blt, nxt_cpu;
    logic [3:0] nxt_aud;
    logic [1:0] starve, starve_nxt;

    logic       q_ref, q_dsk, q_spr, q_bpl, q_cop, q_blt, q_cpu, q_dma;
    logic [3:0] q_aud;

    assign arb  = bus.hpos[0];
    assign slot = (bus.hpos == HPOS_LAST) ? 8'd0 : bus.hpos[8:1] + 8'd1;
    // audio slots 0x0F,0x11,0x13,0x15 map to channels 0..3
    assign aud_idx   = 2'(slot[7:1] - 7'h07);
    // a saturated counter only steals from the blitter when it is not nasty
    assign force_cpu = bus.req_cpu && !bus.blt_nasty && (starve == STARVE_MAX);

    // Decide the owner of the upcoming slot and the next starve count.
    always_comb begin
        nxt_ref    = 1'b0;
        nxt_dsk    = 1'b0;
        nxt_spr    = 1'b0;
        nxt_bpl    = 1'b0;
        nxt_cop    = 1'b0;
        nxt_blt    = 1'b0;
        nxt_cpu    = 1'b0;
        nxt_aud    = 4'b0;
        free_slot  = 1'b0;
        starve_nxt = starve;

        if (slot inside {8'h01, 8'h03, 8'h05, 8'h07}) begin
            nxt_ref = 1'b1;
        end else if (slot inside {8'h09, 8'h0B, 8'h0D}) begin
            if (bus.req_dsk && bus.dsken && bus.dmaen) nxt_dsk = 1'b1;
            else                                       free_slot = 1'b1;
        end else if (slot inside {8'h0F, 8'h11, 8'h13, 8'h15}) begin
            if (bus.req_aud[aud_idx] && bus.dmaen) nxt_aud[aud_idx] = 1'b1;
            else                                   free_slot = 1'b1;
        end else if (slot[0] && slot >= 8'h17 && slot <= 8'h35) begin
            if (bus.req_spr && bus.dmaen && !bus.req_bpl) nxt_spr = 1'b1;
            else                                          free_slot = 1'b1;
        end else begin
            free_slot = 1'b1;
        end

        if (free_slot) begin
            if (bus.req_bpl && bus.dmaen)                    nxt_bpl = 1'b1;
            else if (bus.req_cop && bus.dmaen && !slot[0])   nxt_cop = 1'b1;
            else if (bus.req_blt && bus.dmaen && !force_cpu) nxt_blt = 1'b1;
            else if (bus.req_cpu)                            nxt_cpu = 1'b1;
        end

        if (nxt_cpu || !bus.req_cpu || bus.blt_nasty) starve_nxt = 2'd0;
        else if (nxt_blt && starve != STARVE_MAX)     starve_nxt = starve + 2'd1;
    end

    // Grants and starve count only move at arbitration edges and hold through the slot.
    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            q_ref  <= 1'b0;
            q_dsk  <= 1'b0;
            q_spr  <= 1'b0;
            q_bpl  <= 1'b0;
            q_cop  <= 1'b0;
            q_blt  <= 1'b0;
            q_cpu  <= 1'b0;
            q_aud  <= 4'b0;
            q_dma  <= 1'b0;
            starve <= 2'd0;
        end else if (arb) begin
            q_ref  <= nxt_ref;
            q_dsk  <= nxt_dsk;
            q_spr  <= nxt_spr;
            q_bpl  <= nxt_bpl;
            q_cop  <= nxt_cop;
            q_blt  <= nxt_blt;
            q_cpu  <= nxt_cpu;
            q_aud  <= nxt_aud;
            q_dma  <= nxt_ref | nxt_dsk | nxt_spr | nxt_bpl | nxt_cop | nxt_blt | (|nxt_aud);
            starve <= starve_nxt;
        end
    end

    assign bus.gnt_ref = q_ref;
    assign bus.gnt_dsk = q_dsk;
    assign bus.gnt_spr = q_spr;
    assign bus.gnt_bpl = q_bpl;
    assign bus.gnt_cop = q_cop;
    assign bus.gnt_blt = q_blt;
    assign bus.gnt_cpu = q_cpu;
    assign bus.gnt_aud = q_aud;
    assign bus.dma     = q_dma;
endmodule

// File: tb/tb_dma_slot_arbiter.sv
// Directed bench for dma_slot_arbiter: each slot's expected grant word is
// queued when the arbitration stimulus is applied and checked in both clks
// of the slot.
module tb_dma_slot_arbiter;
    localparam int HTOTAL = 453;

    // grant word: {ref,dsk,spr,bpl,cop,blt,cpu,aud[3:0],dma}
    localparam logic [11:0] G_IDLE = 12'h000;
    localparam logic [11:0] G_REF  = 12'h801;
    localparam logic [11:0] G_DSK  = 12'h401;
    localparam logic [11:0] G_SPR  = 12'h201;
    localparam logic [11:0] G_BPL  = 12'h101;
    localparam logic [11:0] G_COP  = 12'h081;
    localparam logic [11:0] G_BLT  = 12'h041;
    localparam logic [11:0] G_CPU  = 12'h020;
    localparam logic [11:0] G_AUD0 = 12'h003;
    localparam logic [11:0] G_AUD1 = 12'h005;
    localparam logic [11:0] G_AUD2 = 12'h009;
    localparam logic [11:0] G_AUD3 = 12'h011;

    logic clk;
    logic _reset;
    int   vectors = 0;
    int   errors  = 0;
    logic mid_bpl = 1'b0;
    logic [11:0] sb[$];

    dma_slot_arbiter_if bus ();

    dma_slot_arbiter #(.HTOTAL(HTOTAL), .CPU_STARVE(3)) dut (
        .clk    (clk),
        ._reset (_reset),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [11:0] exp);
        logic [11:0] obs;
        obs = {bus.gnt_ref, bus.gnt_dsk, bus.gnt_spr, bus.gnt_bpl, bus.gnt_cop,
               bus.gnt_blt, bus.gnt_cpu, bus.gnt_aud, bus.dma};
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] idle_line(input logic [7:0] n);
        return (n inside {8'h01, 8'h03, 8'h05, 8'h07}) ? G_REF : G_IDLE;
    endfunction

    // Arbitrate slot n (hpos set to its odd lead-in value) and check both clks.
    task automatic run_slot(input logic [7:0] n, input logic [11:0] exp);
        logic [8:0]  h;
        logic [7:0]  s;
        logic [11:0] cur;
        s = n - 8'd1;
        h = (n == 8'd0) ? 9'(HTOTAL) : {s, 1'b1};
        bus.hpos = h;
        sb.push_back(exp);
        @(posedge clk); #1;
        bus.hpos = (h == 9'(HTOTAL)) ? 9'd0 : h + 9'd1;
        cur = sb.pop_front();
        if (mid_bpl) bus.req_bpl = 1'b1;
        @(negedge clk);
        check($sformatf("slot%02h_a", n), cur);
        @(posedge clk); #1;
        @(negedge clk);
        check($sformatf("slot%02h_b", n), cur);
        if (mid_bpl) bus.req_bpl = 1'b0;
    endtask

    initial begin
        _reset = 1'b0;
        bus.hpos = 9'd0;
        bus.dmaen = 1'b0;  bus.dsken = 1'b0;
        bus.req_dsk = 1'b0; bus.req_spr = 1'b0; bus.req_bpl = 1'b0;
        bus.req_cop = 1'b0; bus.req_blt = 1'b0; bus.req_cpu = 1'b0;
        bus.req_aud = 4'b0; bus.blt_nasty = 1'b0;

        // reset state, including an odd edge while held in reset
        #12;
        check("reset", G_IDLE);
        bus.hpos = 9'd1; bus.req_cpu = 1'b1;
        @(posedge clk); #1;
        check("reset_hold", G_IDLE);
        bus.req_cpu = 1'b0; bus.hpos = 9'd452;
        _reset = 1'b1;

        // full line, no requests
        bus.dmaen = 1'b1;
        for (int n = 0; n <= 226; n++) run_slot(8'(n), idle_line(8'(n)));

        // disk slots
        bus.req_dsk = 1'b1; bus.dsken = 1'b1;
        run_slot(8'h09, G_DSK);
        bus.dsken = 1'b0;
        run_slot(8'h0B, G_IDLE);
        bus.dsken = 1'b1; bus.req_bpl = 1'b1;
        run_slot(8'h0D, G_DSK);
        bus.req_bpl = 1'b0; bus.req_dsk = 1'b0;

        // audio slots
        bus.req_aud = 4'b0101;
        run_slot(8'h0F, G_AUD0);
        run_slot(8'h11, G_IDLE);
        run_slot(8'h13, G_AUD2);
        run_slot(8'h15, G_IDLE);
        bus.req_aud = 4'b1010;
        run_slot(8'h11, G_AUD1);
        run_slot(8'h15, G_AUD3);
        bus.req_aud = 4'b0;

        // sprite slots
        bus.req_spr = 1'b1;
        run_slot(8'h17, G_SPR);
        run_slot(8'h18, G_IDLE);
        bus.req_bpl = 1'b1;
        run_slot(8'h19, G_BPL);
        bus.req_bpl = 1'b0;
        run_slot(8'h35, G_SPR);
        run_slot(8'h37, G_IDLE);
        bus.req_spr = 1'b0;

        // master DMA off: only refresh and cpu
        bus.dmaen = 1'b0;
        bus.req_dsk = 1'b1; bus.dsken = 1'b1; bus.req_spr = 1'b1; bus.req_bpl = 1'b1;
        bus.req_cop = 1'b1; bus.req_blt = 1'b1; bus.req_cpu = 1'b1; bus.req_aud = 4'hF;
        run_slot(8'h03, G_REF);
        run_slot(8'h09, G_CPU);
        run_slot(8'h0F, G_CPU);
        run_slot(8'h17, G_CPU);
        run_slot(8'h40, G_CPU);
        run_slot(8'h41, G_CPU);
        bus.req_cpu = 1'b0;
        run_slot(8'h42, G_IDLE);
        bus.req_dsk = 1'b0; bus.req_spr = 1'b0; bus.req_bpl = 1'b0;
        bus.req_cop = 1'b0; bus.req_blt = 1'b0; bus.req_aud = 4'h0;
        bus.dmaen = 1'b1;

        // copper only on even slots
        bus.req_cop = 1'b1; bus.req_cpu = 1'b1;
        run_slot(8'h40, G_COP);
        run_slot(8'h41, G_CPU);
        bus.req_cop = 1'b0;

        // blitter vs cpu starvation
        bus.req_blt = 1'b1;
        run_slot(8'h50, G_BLT); run_slot(8'h51, G_BLT);
        run_slot(8'h52, G_BLT); run_slot(8'h53, G_CPU);
        run_slot(8'h54, G_BLT); run_slot(8'h55, G_BLT);
        run_slot(8'h56, G_BLT); run_slot(8'h57, G_CPU);

        // nasty blitter clears a partly built count
        run_slot(8'h58, G_BLT); run_slot(8'h59, G_BLT);
        bus.blt_nasty = 1'b1;
        for (int n = 'h60; n <= 'h67; n++) run_slot(8'(n), G_BLT);
        bus.blt_nasty = 1'b0;
        run_slot(8'h68, G_BLT); run_slot(8'h69, G_BLT);
        run_slot(8'h6A, G_BLT); run_slot(8'h6B, G_CPU);

        // saturated count holds across bpl and cop wins
        run_slot(8'h70, G_BLT); run_slot(8'h71, G_BLT); run_slot(8'h72, G_BLT);
        bus.req_bpl = 1'b1;
        run_slot(8'h73, G_BPL);
        bus.req_bpl = 1'b0; bus.req_cop = 1'b1;
        run_slot(8'h74, G_COP);
        bus.req_cop = 1'b0;
        run_slot(8'h75, G_CPU);

        // request change mid-slot does not disturb the grant
        mid_bpl = 1'b1;
        run_slot(8'h76, G_BLT);
        mid_bpl = 1'b0;

        // fixed sprite slots win over a saturated count, which holds
        bus.req_cpu = 1'b0;
        run_slot(8'h1F, G_BLT);
        bus.req_cpu = 1'b1; bus.req_spr = 1'b1;
        run_slot(8'h20, G_BLT); run_slot(8'h21, G_SPR);
        run_slot(8'h22, G_BLT); run_slot(8'h23, G_SPR);
        run_slot(8'h24, G_BLT); run_slot(8'h25, G_SPR);
        run_slot(8'h26, G_CPU); run_slot(8'h27, G_SPR);
        run_slot(8'h28, G_BLT);
        bus.req_spr = 1'b0; bus.req_blt = 1'b0;

        // end-of-line wrap into slot 0
        run_slot(8'h00, G_CPU);
        run_slot(8'h01, G_REF);

        // async reset mid-slot and restart
        bus.req_cpu = 1'b0; bus.req_dsk = 1'b1; bus.dsken = 1'b1;
        run_slot(8'h09, G_DSK);
        bus.req_cpu = 1'b1; bus.hpos = 9'h13;
        @(posedge clk); #2;
        check("rst_pre", G_CPU);
        _reset = 1'b0; #1;
        check("rst_async", G_IDLE);
        bus.hpos = 9'h14;
        @(posedge clk); #1;
        bus.hpos = 9'h15;
        @(posedge clk); #1;
        check("rst_held", G_IDLE);
        _reset = 1'b1; bus.hpos = 9'h16;
        @(posedge clk); #1;
        check("rst_even_edge", G_IDLE);
        run_slot(8'h0C, G_CPU);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
